// File: rtl/branch_resolve_bht.sv
// branch_resolve_bht
//   Resolves MIPS conditional branches in the D stage and keeps a table of
//   2-bit saturating counters that the F stage reads to predict the branch
//   direction. Resolving a branch updates its counter. A wrong prediction
//   raises a registered one-cycle mispredict pulse.
//
// Ports
//   clk, reset        rising-edge clock; asynchronous active-high reset
//   lk_valid, lk_pc   F-stage lookup request
//   lk_pred_taken     predicted direction (combinational, no bypass)
//   rs_valid, rs_stall, rs_pc, rs_type, rs_in0, rs_in1, rs_pred_taken
//                     D-stage resolve request
//   rs_taken          actual outcome (combinational)
//   mispredict        registered flush/redirect pulse
//   stat_clr          synchronous clear of br_cnt / mis_cnt
//   br_cnt, mis_cnt   saturating branch and mispredict counts
//   err_multi         sticky flag: a multi-hot rs_type was fired
//
// Handshake: rs_valid qualifies a resolve request for one cycle. A request
// takes effect (table write, counting, mispredict) only when rs_valid is high
// and rs_stall is low at the rising edge. No ready signal exists: the unit
// accepts one resolve and one lookup every cycle. lk_valid only gates the
// prediction output.
module branch_resolve_bht #(
  parameter int         DATA_W   = 32,
  parameter int         IDX_W    = 6,
  parameter int         CNT_W    = 32,
  parameter logic [1:0] INIT_CTR = 2'b01
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lk_valid,
  input  logic [31:0]       lk_pc,
  output logic              lk_pred_taken,
  input  logic              rs_valid,
  input  logic              rs_stall,
  input  logic [31:0]       rs_pc,
  input  logic [5:0]        rs_type,
  input  logic [DATA_W-1:0] rs_in0,
  input  logic [DATA_W-1:0] rs_in1,
  input  logic              rs_pred_taken,
  output logic              rs_taken,
  output logic              mispredict,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  br_cnt,
  output logic [CNT_W-1:0]  mis_cnt,
  output logic              err_multi
);

  localparam int             DEPTH   = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       ctr [DEPTH];
  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] rs_idx;
  logic [1:0]       ctr_cur;
  logic [1:0]       ctr_next;
  logic [5:0]       cond;
  logic             sign0;
  logic             zero0;
  logic             eq01;
  logic             fire;
  logic             br;
  logic             multi_hot;
  logic             unused_pc;

  // Word-aligned PCs: bits [1:0] and the high bits never select an entry.
  assign lk_idx    = lk_pc[IDX_W+1:2];
  assign rs_idx    = rs_pc[IDX_W+1:2];
  assign unused_pc = ^{lk_pc, rs_pc};

  // Reads the registered table, so a same-cycle update is seen only next cycle.
  assign lk_pred_taken = lk_valid & ctr[lk_idx][1];

  // Condition vector, same bit order as rs_type: {bne,bltz,blez,bgtz,bgez,beq}.
  assign sign0 = rs_in0[DATA_W-1];
  assign zero0 = (rs_in0 == '0);
  assign eq01  = (rs_in0 == rs_in1);

  always_comb begin
    cond    = '0;
    cond[0] = eq01;
    cond[1] = ~sign0;
    cond[2] = ~sign0 & ~zero0;
    cond[3] = sign0 | zero0;
    cond[4] = sign0;
    cond[5] = ~eq01;
  end

  // A multi-hot type resolves as the OR of its selected conditions.
  assign rs_taken  = rs_valid & |(rs_type & cond);
  assign fire      = rs_valid & ~rs_stall;
  assign br        = fire & (rs_type != 6'd0);
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_hot = |(rs_type & (rs_type - 6'd1));

  assign ctr_cur = ctr[rs_idx];

  always_comb begin
    ctr_next = ctr_cur;
    if (rs_taken) begin
      if (ctr_cur != 2'd3) ctr_next = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'd0) ctr_next = ctr_cur - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ctr[i] <= INIT_CTR;
    end else if (br) begin
      ctr[rs_idx] <= ctr_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mispredict <= 1'b0;
      err_multi  <= 1'b0;
    end else begin
      mispredict <= br & (rs_taken != rs_pred_taken);
      if (fire && multi_hot) err_multi <= 1'b1;
    end
  end

  // stat_clr wins over a same-cycle increment; counts stick at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_cnt  <= '0;
      mis_cnt <= '0;
    end else if (stat_clr) begin
      br_cnt  <= '0;
      mis_cnt <= '0;
    end else begin
      if (br && br_cnt != CNT_MAX) br_cnt <= br_cnt + CNT_ONE;
      if (br && (rs_taken != rs_pred_taken) && mis_cnt != CNT_MAX)
        mis_cnt <= mis_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_branch_resolve_bht.sv
// tb_branch_resolve_bht
//   Self-checking bench for branch_resolve_bht (CNT_W = 4 so saturation is
//   reachable). A behavioural model tracks the counter table, statistics and
//   sticky error flag. Expected mispredict values are queued when a resolve
//   is driven and popped when the registered pulse appears one edge later.
module tb_branch_resolve_bht;

  localparam int CW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          lk_valid = 1'b0;
  logic [31:0]   lk_pc = '0;
  logic          lk_pred_taken;
  logic          rs_valid = 1'b0;
  logic          rs_stall = 1'b0;
  logic [31:0]   rs_pc = '0;
  logic [5:0]    rs_type = '0;
  logic [31:0]   rs_in0 = '0;
  logic [31:0]   rs_in1 = '0;
  logic          rs_pred_taken = 1'b0;
  logic          rs_taken;
  logic          mispredict;
  logic          stat_clr = 1'b0;
  logic [CW-1:0] br_cnt;
  logic [CW-1:0] mis_cnt;
  logic          err_multi;

  branch_resolve_bht #(.DATA_W(32), .IDX_W(6), .CNT_W(CW), .INIT_CTR(2'b01)) dut (
    .clk(clk), .reset(reset),
    .lk_valid(lk_valid), .lk_pc(lk_pc), .lk_pred_taken(lk_pred_taken),
    .rs_valid(rs_valid), .rs_stall(rs_stall), .rs_pc(rs_pc), .rs_type(rs_type),
    .rs_in0(rs_in0), .rs_in1(rs_in1), .rs_pred_taken(rs_pred_taken),
    .rs_taken(rs_taken), .mispredict(mispredict), .stat_clr(stat_clr),
    .br_cnt(br_cnt), .mis_cnt(mis_cnt), .err_multi(err_multi)
  );

  localparam logic [5:0] T_BEQ = 6'b000001, T_BGEZ = 6'b000010, T_BGTZ = 6'b000100,
                         T_BLEZ = 6'b001000, T_BLTZ = 6'b010000, T_BNE = 6'b100000;

  // ---------------- model and scoreboard ----------------
  logic [1:0] m_ctr [64];
  int         m_br, m_mis;
  logic       m_err;
  logic [0:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_ctr[i] = 2'b01;
    m_br = 0; m_mis = 0; m_err = 1'b0;
    exp_q.delete();
  endtask

  function automatic logic m_pred(input logic [31:0] pc);
    return m_ctr[pc[7:2]][1];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic lv, input logic [31:0] lpc, input logic rv, input logic st,
                       input logic [31:0] pc, input logic [5:0] typ, input logic [31:0] a,
                       input logic [31:0] b, input logic pred, input logic clr);
    lk_valid = lv; lk_pc = lpc; rs_valid = rv; rs_stall = st; rs_pc = pc;
    rs_type = typ; rs_in0 = a; rs_in1 = b; rs_pred_taken = pred; stat_clr = clr;
  endtask

  // Called at a falling edge with inputs set; checks combinational outputs,
  // queues the expected pulse, crosses one rising edge, then checks registers.
  task automatic tick();
    logic [5:0] cond;
    logic exp_pred, exp_taken, fire, br, mis;
    logic [5:0] idx;
    #1;
    exp_pred = lk_valid & m_ctr[lk_pc[7:2]][1];
    cond[0] = (rs_in0 == rs_in1);
    cond[1] = ($signed(rs_in0) >= 0);
    cond[2] = ($signed(rs_in0) > 0);
    cond[3] = ($signed(rs_in0) <= 0);
    cond[4] = ($signed(rs_in0) < 0);
    cond[5] = (rs_in0 != rs_in1);
    exp_taken = rs_valid & |(rs_type & cond);
    check_eq("lk_pred_taken", lk_pred_taken, exp_pred);
    check_eq("rs_taken", rs_taken, exp_taken);
    fire = rs_valid & ~rs_stall;
    br = fire & (rs_type != 0);
    mis = br & (exp_taken != rs_pred_taken);
    exp_q.push_back(mis);
    @(posedge clk);
    idx = rs_pc[7:2];
    if (br) begin
      if (exp_taken) m_ctr[idx] = (m_ctr[idx] == 2'd3) ? 2'd3 : m_ctr[idx] + 2'd1;
      else           m_ctr[idx] = (m_ctr[idx] == 2'd0) ? 2'd0 : m_ctr[idx] - 2'd1;
    end
    if (stat_clr) begin
      m_br = 0; m_mis = 0;
    end else begin
      if (br && m_br < 15) m_br++;
      if (mis && m_mis < 15) m_mis++;
    end
    if (fire && $countones(rs_type) > 1) m_err = 1'b1;
    #1;
    check_eq("exp_q_size", exp_q.size(), 1);
    if (exp_q.size() > 0) check_eq("mispredict", mispredict, exp_q.pop_front());
    check_eq("br_cnt", br_cnt, m_br);
    check_eq("mis_cnt", mis_cnt, m_mis);
    check_eq("err_multi", err_multi, m_err);
    @(negedge clk);
  endtask

  // Resolve a non-stalled branch while looking up the same PC in the same cycle.
  task automatic res(input logic [31:0] pc, input logic [5:0] typ, input logic [31:0] a,
                     input logic [31:0] b, input logic pred);
    drive(1'b1, pc, 1'b1, 1'b0, pc, typ, a, b, pred, 1'b0);
    tick();
  endtask

  task automatic look(input logic [31:0] pc);
    drive(1'b1, pc, 1'b0, 1'b0, 32'h0, 6'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] bnd [3];

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_mispredict", mispredict, 0);
    check_eq("rst_br_cnt", br_cnt, 0);
    check_eq("rst_mis_cnt", mis_cnt, 0);
    check_eq("rst_err_multi", err_multi, 0);
    reset = 1'b0;

    // First beq: weakly not-taken table, actual taken -> mispredict.
    look(32'h3000);
    res(32'h3000, T_BEQ, 32'd5, 32'd5, 1'b0);
    check_eq("beq_mis_cnt", mis_cnt, 1);
    check_eq("beq_br_cnt", br_cnt, 1);
    look(32'h3000);
    check_eq("beq_pred_after", m_pred(32'h3000), 1);

    // Train to saturation, then walk back down.
    for (int i = 0; i < 4; i++) res(32'h3000, T_BGTZ, 32'd7, 32'd0, m_pred(32'h3000));
    res(32'h3000, T_BGTZ, 32'd0, 32'd0, 1'b1);
    look(32'h3000);
    res(32'h3000, T_BGTZ, 32'd0, 32'd0, 1'b1);
    look(32'h3000);

    // Sign boundaries for the single-operand compares.
    bnd[0] = 32'h0000_0000; bnd[1] = 32'h8000_0000; bnd[2] = 32'h7FFF_FFFF;
    for (int t = 1; t <= 4; t++)
      for (int v = 0; v < 3; v++)
        res(32'h3200, 6'(1 << t), bnd[v], 32'h0, 1'b0);

    // Stalled mispredicting branch has no side effects; unstalled one pulses.
    drive(1'b1, 32'h3080, 1'b1, 1'b1, 32'h3080, T_BNE, 32'd1, 32'd2, 1'b0, 1'b0);
    tick();
    tick();
    res(32'h3080, T_BNE, 32'd1, 32'd2, 1'b0);
    look(32'h3080);

    // Aliasing entries, plus same-cycle resolve/lookup returning the old value.
    res(32'h3004, T_BEQ, 32'd3, 32'd3, 1'b0);
    look(32'h3104);
    res(32'h3104, T_BNE, 32'd3, 32'd3, 1'b1);
    res(32'h3104, T_BNE, 32'd3, 32'd3, 1'b0);
    look(32'h3004);

    // Not-a-branch with rs_valid high.
    res(32'h3008, 6'h00, 32'd1, 32'd1, 1'b1);

    // 20 mispredicts saturate the 4-bit counters.
    for (int i = 0; i < 20; i++) res(32'h3300, T_BNE, 32'd1, 32'd9, 1'b0);
    check_eq("sat_mis_cnt", mis_cnt, 15);
    check_eq("sat_br_cnt", br_cnt, 15);

    // Clear beats a same-cycle mispredict increment.
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h3300, T_BNE, 32'd1, 32'd9, 1'b0, 1'b1);
    tick();
    check_eq("clr_mis_cnt", mis_cnt, 0);

    // Multi-hot type sets the sticky flag; it survives stat_clr.
    res(32'h3010, T_BEQ | T_BGEZ, 32'd4, 32'd5, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 6'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    check_eq("err_sticky", err_multi, 1);

    // Random traffic.
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a, b, pc;
      logic [5:0] typ;
      pc = 32'h3000 + ($urandom_range(0, 7) << 2) + ($urandom_range(0, 1) << 8);
      case ($urandom_range(0, 3))
        0: a = 32'h0;
        1: a = 32'h8000_0000;
        2: a = 32'h7FFF_FFFF;
        default: a = $urandom();
      endcase
      b = ($urandom_range(0, 1) == 1) ? a : $urandom();
      typ = ($urandom_range(0, 7) == 0) ? 6'h0 : 6'(1 << $urandom_range(0, 5));
      drive($urandom_range(0, 1) == 1, pc ^ ($urandom_range(0, 1) << 2),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, pc, typ, a, b,
            $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
      tick();
    end

    // Mid-stream reset: asynchronous clear, pending update discarded.
    res(32'h3400, T_BEQ, 32'd1, 32'd1, 1'b1);
    res(32'h3400, T_BEQ, 32'd1, 32'd1, 1'b1);
    res(32'h3400, T_BNE, 32'd1, 32'd1, 1'b1);
    check_eq("pre_rst_mispredict", mispredict, 1);
    drive(1'b1, 32'h3400, 1'b1, 1'b0, 32'h3400, T_BNE, 32'd1, 32'd1, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_mispredict", mispredict, 0);
    check_eq("arst_br_cnt", br_cnt, 0);
    check_eq("arst_mis_cnt", mis_cnt, 0);
    check_eq("arst_err_multi", err_multi, 0);
    check_eq("arst_lk_pred", lk_pred_taken, 0);
    @(posedge clk);
    #1;
    check_eq("arst_hold_br_cnt", br_cnt, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    look(32'h3400);

    check_eq("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
